// File: rtl/out_port_mc.sv
// out_port_mc: CHANNELS shadow output registers feeding a shared {channel, value} FIFO.
// Optional build macro OUT_PORT_CHANGE_FILTER_EN: queue only writes that change a shadow.
module out_port_mc #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic [CW-1:0]    wr_chan,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CW-1:0]    rd_chan,
  output logic [WIDTH-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_chan,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic [7:0]       drop_count,
  input  logic             clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int RW = CW + WIDTH;
  localparam logic [CW:0]   NCH      = (CW + 1)'(CHANNELS);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] shadow_q [CHANNELS];
  logic [RW-1:0]    mem_q    [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;

  logic          qualified, changed, push, pop, full, accept, drop;
  logic [CW-1:0] wr_idx;

  // Output handshake: a record transfers at a rising edge where out_valid && out_ready;
  // out_chan/out_data hold steady while out_valid && !out_ready.
  always_comb begin
    qualified = write_en && ({1'b0, wr_chan} < NCH);
    wr_idx    = qualified ? wr_chan : '0;
`ifdef OUT_PORT_CHANGE_FILTER_EN
    changed   = (data_in != shadow_q[wr_idx]);
`else
    changed   = 1'b1;
`endif
    push      = qualified && changed;
    full      = (level_q == FULL_LVL);
    pop       = (level_q != '0) && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    accept    = push && (!full || pop);
    drop      = push && full && !pop;
    level_d   = level_q + LW'(accept) - LW'(pop);

    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = clr_ovf ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) shadow_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++)    mem_q[i]    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      if (qualified) shadow_q[wr_idx] <= data_in;
      if (accept) begin
        mem_q[wr_ptr_q] <= {wr_idx, data_in};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign rd_data              = ({1'b0, rd_chan} < NCH) ? shadow_q[rd_chan] : '0;
  assign out_valid            = (level_q != '0);
  assign {out_chan, out_data} = mem_q[rd_ptr_q];
  assign level                = level_q;
  assign overflow             = ovf_q;
  assign drop_count           = drop_q;

endmodule
